// File: rtl/axi_lite_ram.sv
// AXI4-Lite slave RAM: byte-strobe writes, independent AW/W holding registers, SLVERR on out-of-range.
// Define AXI_LITE_RAM_ALIGN_CHECK_EN to treat unaligned addresses as errors.
module axi_lite_ram #(
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 8,
    parameter int MEM_DEPTH       = 48
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [AXIL_ADDR_WIDTH-1:0]   awaddr,
    input  logic                         wvalid,
    output logic                         wready,
    input  logic [AXIL_DATA_WIDTH-1:0]   wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0] wstrb,
    output logic                         bvalid,
    input  logic                         bready,
    output logic [1:0]                   bresp,
    input  logic                         arvalid,
    output logic                         arready,
    input  logic [AXIL_ADDR_WIDTH-1:0]   araddr,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [AXIL_DATA_WIDTH-1:0]   rdata,
    output logic [1:0]                   rresp
);

    localparam int STRB_W   = AXIL_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = AXIL_ADDR_WIDTH - ADDR_LSB;
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // a source holds valid and payload stable until that edge, ready never waits on valid.

    logic                       ready_en;
    logic                       aw_full;
    logic [IDX_W-1:0]           aw_idx;
    logic                       aw_ok;
    logic                       w_full;
    logic [AXIL_DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]          w_strb;
    logic [AXIL_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             wr_exec;
    logic [IDX_W-1:0] aw_idx_in;
    logic [IDX_W-1:0] ar_idx;
    logic             aw_ok_in;
    logic             ar_ok;

    assign awready = ready_en && !aw_full;
    assign wready  = ready_en && !w_full;
    assign arready = ready_en && (!rvalid || rready);

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign wr_exec = aw_full && w_full && (!bvalid || bready);

    assign aw_idx_in = awaddr[AXIL_ADDR_WIDTH-1:ADDR_LSB];
    assign ar_idx    = araddr[AXIL_ADDR_WIDTH-1:ADDR_LSB];

`ifdef AXI_LITE_RAM_ALIGN_CHECK_EN
    assign aw_ok_in = ({1'b0, aw_idx_in} < DEPTH_L) && (awaddr[ADDR_LSB-1:0] == '0);
    assign ar_ok    = ({1'b0, ar_idx} < DEPTH_L) && (araddr[ADDR_LSB-1:0] == '0);
`else
    logic unused_low_bits;
    assign unused_low_bits = ^{awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};
    assign aw_ok_in = ({1'b0, aw_idx_in} < DEPTH_L);
    assign ar_ok    = ({1'b0, ar_idx} < DEPTH_L);
`endif

    // Range is resolved at AW capture, so execute only needs the stored flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en <= 1'b0;
            aw_full  <= 1'b0;
            aw_idx   <= '0;
            aw_ok    <= 1'b0;
            w_full   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            ready_en <= 1'b1;
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= aw_idx_in;
                aw_ok   <= aw_ok_in;
            end else if (wr_exec) begin
                aw_full <= 1'b0;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end else if (wr_exec) begin
                w_full <= 1'b0;
            end
            if (wr_exec) begin
                bvalid <= 1'b1;
                bresp  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= ar_ok ? mem[ar_idx] : '0;
            rresp  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

    // Storage has no reset; a same-edge read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_exec && aw_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) begin
                    mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_ram.sv
// Randomized self-checking bench for axi_lite_ram against a word-array reference model.
module tb_axi_lite_ram;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 48;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    axi_lite_ram #(.AXIL_DATA_WIDTH(DW), .AXIL_ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic model_ok(input logic [AW-1:0] a);
        logic ok;
        ok = (int'(a) / 4) < DEPTH;
`ifdef AXI_LITE_RAM_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic logic [1:0] model_resp(input logic [AW-1:0] a);
        return model_ok(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        return model_ok(a) ? model_mem[int'(a) / 4] : '0;
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                        input logic [3:0] s);
        if (model_ok(a)) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) model_mem[int'(a) / 4][8*i +: 8] = d[8*i +: 8];
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_aw(input logic [AW-1:0] a);
        int n = 0;
        @(negedge clk);
        awvalid = 1'b1;
        awaddr  = a;
        while (!awready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("aw_hs", 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [DW-1:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge clk);
        wvalid = 1'b1;
        wdata  = d;
        wstrb  = s;
        while (!wready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("w_hs", 32'(wready), 32'd1);
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int n = 0;
        while (!bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b_hs", 32'(bvalid), 32'd1);
        resp = bresp;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bready = 1'b1;
        fork
            drive_aw(a);
            drive_w(d, s);
        join
        wait_b(resp);
        model_write(a, d, s);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                            output logic [1:0] resp);
        int n = 0;
        rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = a;
        while (!arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ar_hs", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check("r_lat", 32'(rvalid), 32'd1);
        d    = rdata;
        resp = rresp;
    endtask

    task automatic write_chk(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        logic [1:0] resp;
        logic [1:0] exp_resp;
        exp_resp = model_resp(a);
        axi_write(a, d, s, resp);
        check("bresp", 32'(resp), 32'(exp_resp));
    endtask

    task automatic read_chk(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        logic [1:0]    resp;
        exp_q.push_back(model_read(a));
        axi_read(a, d, resp);
        check("rresp", 32'(resp), 32'(model_resp(a)));
        check("rdata", d, exp_q.pop_front());
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0] d, old_v, new_v;
        logic [1:0]    resp;

        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_bresp",   32'(bresp),   32'd0);
        check("rst_rresp",   32'(rresp),   32'd0);
        check("rst_rdata",   rdata,        32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'({awready, wready, arready}), 32'd7);

        for (int i = 0; i < DEPTH; i++) write_chk(AW'(i * 4), $urandom, 4'hF);

        // strobe write
        write_chk(8'h10, 32'h11223344, 4'hF);
        write_chk(8'h10, 32'hAABBCCDD, 4'b0101);
        axi_read(8'h10, d, resp);
        check("strobe_rdata", d, 32'h11BB33DD);
        check("strobe_rresp", 32'(resp), 32'd0);

        // out of range
        axi_write(8'hC0, 32'hDEADBEEF, 4'hF, resp);
        check("oor_bresp", 32'(resp), 32'h2);
        axi_read(8'hC0, d, resp);
        check("oor_rdata", d, 32'd0);
        check("oor_rresp", 32'(resp), 32'h2);
        write_chk(8'hBC, 32'd5, 4'hF);
        axi_read(8'hBC, d, resp);
        check("last_word", d, 32'd5);
        check("last_rresp", 32'(resp), 32'd0);

        // W three cycles ahead of AW
        @(negedge clk);
        bready = 1'b1;
        wvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF;
        @(negedge clk);
        wvalid = 1'b0;
        check("w_first_hold", 32'(wready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        awvalid = 1'b1; awaddr = 8'h24;
        check("w_first_awready", 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        check("w_first_b_early", 32'(bvalid), 32'd0);
        @(negedge clk);
        check("w_first_bvalid", 32'(bvalid), 32'd1);
        check("w_first_bresp", 32'(bresp), 32'd0);
        model_write(8'h24, 32'h0BADF00D, 4'hF);
        read_chk(8'h24);

        // back-to-back reads
        rready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(model_read(AW'(i * 4)));
        @(negedge clk);
        arvalid = 1'b1; araddr = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check("b2b_arready", 32'(arready), 32'd1);
            @(negedge clk);
            if (i < 7) araddr = AW'((i + 1) * 4);
            else arvalid = 1'b0;
            check("b2b_rvalid", 32'(rvalid), 32'd1);
            check("b2b_rdata", rdata, exp_q.pop_front());
        end
        @(negedge clk);
        check("b2b_rvalid_end", 32'(rvalid), 32'd0);

        // read stall with rready low
        rready = 1'b0; arvalid = 1'b1; araddr = 8'h00;
        @(negedge clk);
        araddr = 8'h04;
        check("stall_arready", 32'(arready), 32'd0);
        check("stall_rvalid", 32'(rvalid), 32'd1);
        @(negedge clk);
        check("stall_arready2", 32'(arready), 32'd0);
        check("stall_rdata", rdata, model_read(8'h00));
        rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        check("stall_next_rvalid", 32'(rvalid), 32'd1);
        check("stall_next_rdata", rdata, model_read(8'h04));
        @(negedge clk);
        check("stall_rvalid_end", 32'(rvalid), 32'd0);

        // read and write execute on the same edge
        old_v = model_read(8'h30);
        new_v = $urandom;
        @(negedge clk);
        bready = 1'b1; rready = 1'b1;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 8'h30; wdata = new_v; wstrb = 4'hF;
        check("rdw_ready", 32'({awready, wready}), 32'd3);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        arvalid = 1'b1; araddr = 8'h30;
        @(negedge clk);
        arvalid = 1'b0;
        check("rdw_rvalid", 32'(rvalid), 32'd1);
        check("rdw_old_data", rdata, old_v);
        check("rdw_bvalid", 32'(bvalid), 32'd1);
        model_write(8'h30, new_v, 4'hF);
        read_chk(8'h30);

        // write backpressure: first write out of range, second queued behind it
        new_v = $urandom;
        @(negedge clk);
        bready = 1'b0;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 8'hC4; wdata = 32'h12345678; wstrb = 4'hF;
        @(negedge clk);
        awaddr = 8'h34; wdata = new_v;
        check("bp_aw_full", 32'(awready), 32'd0);
        @(negedge clk);
        check("bp_bvalid1", 32'(bvalid), 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_stall_ready", 32'({awready, wready}), 32'd0);
            check("bp_stall_bvalid", 32'(bvalid), 32'd1);
            check("bp_stall_bresp", 32'(bresp), 32'h2);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        check("bp_bvalid2", 32'(bvalid), 32'd1);
        check("bp_bresp2", 32'(bresp), 32'd0);
        model_write(8'h34, new_v, 4'hF);
        @(negedge clk);
        check("bp_bvalid_end", 32'(bvalid), 32'd0);
        check("bp_ready_back", 32'({awready, wready}), 32'd3);
        read_chk(8'h34);

        // unaligned access
        write_chk(8'h12, 32'hCAFE0012, 4'hF);
        read_chk(8'h10);
        read_chk(8'h12);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) write_chk(a, $urandom, 4'($urandom_range(0, 15)));
            else read_chk(a);
        end

        // reset in the middle of a write
        write_chk(8'h20, 32'h5A5A1234, 4'hF);
        @(negedge clk);
        rready = 1'b0;
        awvalid = 1'b1; awaddr = 8'h20;
        arvalid = 1'b1; araddr = 8'h00;
        @(negedge clk);
        awvalid = 1'b0; arvalid = 1'b0;
        check("mid_pre_rvalid", 32'(rvalid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rvalid", 32'(rvalid), 32'd0);
        check("mid_bvalid", 32'(bvalid), 32'd0);
        check("mid_readies", 32'({awready, wready, arready}), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rready = 1'b1; bready = 1'b1;
        repeat (2) @(negedge clk);
        wvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        check("mid_wready", 32'(wready), 32'd1);
        @(negedge clk);
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_no_exec", 32'(bvalid), 32'd0);
        end
        read_chk(8'h20);
        drive_aw(8'h3C);
        wait_b(resp);
        check("mid_bresp", 32'(resp), 32'd0);
        model_write(8'h3C, 32'hFFFFFFFF, 4'hF);
        read_chk(8'h3C);
        read_chk(8'h20);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_ram.md
# axi_lite_ram

Parametrised AXI4-Lite slave RAM, the successor of `axi_lite_memory`. It supports a non-power-of-two depth, byte-strobe writes, independent AW/W acceptance, SLVERR responses for out-of-range accesses, and full-throughput reads. It sits behind the AXI-Lite interconnect as a scratch or configuration memory.

## Interface
- `AXIL_DATA_WIDTH`, 32: data width in bits (32 or 64).
- `AXIL_ADDR_WIDTH`, 8: byte-address width.
- `MEM_DEPTH`, 48: number of data words, 1..2^(AXIL_ADDR_WIDTH-ADDR_LSB). ADDR_LSB = log2(AXIL_DATA_WIDTH/8).
- `clk` in 1: clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `awvalid`/`awready` in/out 1 each; `awaddr` in AXIL_ADDR_WIDTH.
- `wvalid`/`wready` in/out 1 each; `wdata` in AXIL_DATA_WIDTH; `wstrb` in AXIL_DATA_WIDTH/8.
- `bvalid` out 1, `bready` in 1, `bresp` out 2.
- `arvalid`/`arready` in/out 1 each; `araddr` in AXIL_ADDR_WIDTH.
- `rvalid` out 1, `rready` in 1, `rdata` out AXIL_DATA_WIDTH, `rresp` out 2.

## Operation
- Word index = addr[AXIL_ADDR_WIDTH-1:ADDR_LSB]. An access is in range when index < MEM_DEPTH.
- **AW holding register:** one entry, `aw_full`.
  - `awready` = `ready_en && !aw_full`.
  - AW handshake sets `aw_full` and captures the address.
- **W holding register:** one entry, `w_full`.
  - `wready` = `ready_en && !w_full`.
  - W handshake captures data and strobe.
  - AW and W may arrive in either order or in the same cycle.
- **Write execute:** occurs on an edge where `aw_full && w_full && (!bvalid || bready)`.
  - In range: byte i of the word is written iff `wstrb[i]`. Response `bresp`=2'b00.
  - Out of range: memory is unchanged. Response `bresp`=2'b10 (SLVERR).
  - On the same edge: `bvalid`<=1, and `aw_full` and `w_full` clear.
- **B channel:** `bvalid` clears on `bvalid && bready`, unless a new execute occurs on the same edge. Execute and B handshake in the same cycle are legal.
- **Read:**
  - `arready` = `ready_en && (!rvalid || rready)`.
  - On AR handshake, `rdata`/`rresp` load from memory, or 0/2'b10 when out of range, and `rvalid`<=1.
  - Otherwise `rvalid` clears on `rready`.
- **Read-during-write:** a read fetch and a write execute to the same word on the same edge return the old data.
- **Memory contents:** not cleared by reset, and undefined until written.
- **`ready_en`:** a register, 0 in reset, set on the first edge after `reset_n` deasserts.

## Timing
- **Reset values:**
  - `awready`, `wready`, `arready`, `bvalid`, `rvalid` = 0.
  - `bresp`, `rresp` = 2'b00; `rdata` = 0.
  - Holding registers empty.
- **Write latency:**
  - AW and W both accepted at edge N: execute at edge N+1, `bvalid` high after N+1.
  - `awready`/`wready` reassert after N+1.
  - Sustained write throughput: 1 per 2 cycles.
- **Write backpressure:** with `bready`=0 and `bvalid`=1, a second write fills both holding registers and then stalls. Both readies stay low until the B handshake.
- **Read latency:** AR accepted at edge N gives `rvalid` after N. With `rready` held 1, reads sustain 1 per cycle.
- **Stability:** `rdata`/`rresp` and `bresp` are stable while valid && !ready.
- **Reset mid-transaction:** in-flight AW/W/B/R state is discarded and all valids drop immediately. A partially captured write never reaches memory.

## Configuration
- `AXI_LITE_RAM_ALIGN_CHECK_EN`
  - Defined: an access with addr[ADDR_LSB-1:0] != 0 is an error. The write is dropped with `bresp`=2'b10; a read returns `rdata`=0, `rresp`=2'b10.
  - Undefined: low address bits are ignored and such accesses behave as aligned.

## Test plan
All scenarios use DATA=32, ADDR=8, DEPTH=48.
1. **Strobe write:** write 0x11223344 to 0x10 with `wstrb`=4'hF, then 0xAABBCCDD with `wstrb`=4'b0101; read 0x10 -> `rdata`=0x11BB33DD, `rresp`=00.
2. **Out of range:** write 0xDEADBEEF to 0xC0 -> `bresp`=10. Read 0xC0 -> `rdata`=0, `rresp`=10. Read 0xBC after writing 5 there -> 5, `rresp`=00.
3. **W before AW:** W presented 3 cycles before AW, `bready`=1 -> `bvalid` one cycle after AW accepted, `bresp`=00, data readable.
4. **Back-to-back reads:** `rready`=1, 8 consecutive ARs to 0x00..0x1C -> `arready` stays 1, 8 `rvalid` beats on consecutive cycles in order. With `rready`=0, `arready` drops after the first beat.
5. **Reset mid-write:** pulse `reset_n` low after AW accepted, before W -> all valids 0. Read of that address afterwards returns the previously written value.
6. **Align check:** with `AXI_LITE_RAM_ALIGN_CHECK_EN`, write to 0x12 -> `bresp`=10 and memory unchanged. Without it, the same write updates word 0x10.
